// File: rtl/mdio_controller.sv
// MDIO station-management initiator: MDC = CLK/2, 32-bit frame, no preamble, MSB first.
// Read frames release the bus at turnaround and shift 16 bits in from MDIO_IN.
module mdio_controller #(
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MDIO_START,
  input  logic [FRAME_W-1:0] T_DATA,
  input  logic               MDIO_IN,
  output logic               MDC,
  output logic               MDIO_OE,
  output logic               MDIO_OUT,
  output logic [DATA_W-1:0]  RD_DATA,
  output logic               DATA_RDY,
  output logic               MDIO_DONE,
  output logic               BUSY,
  output logic               ERR
);

  localparam logic [1:0] StartCode = 2'b01;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpRead    = 2'b10;
  localparam logic [4:0] LastHdr   = 5'd18;
  localparam logic [4:0] LastTa    = 5'd16;

  typedef enum logic [2:0] {
    StIdle,
    StSendHdr,
    StTurn,
    StReadData,
    StSendData,
    StFinish
  } state_e;

  state_e               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [DATA_W-2:0]    rx_q;
  logic [4:0]           bit_cnt_q;
  logic                 armed_q;

  logic                 mdc_fall;
  logic                 frame_ok;
  logic                 is_read;
  logic [4:0]           next_bit;

  // The edge on which MDC is currently high is the one that drives it low.
  assign mdc_fall = MDC;
  assign is_read  = (frame_q[29:28] == OpRead);
  assign next_bit = bit_cnt_q - 5'd1;
  assign frame_ok = (T_DATA[31:30] == StartCode) &&
                    ((T_DATA[29:28] == OpWrite) || (T_DATA[29:28] == OpRead));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MDC       <= 1'b0;
      MDIO_OE   <= 1'b0;
      MDIO_OUT  <= 1'b0;
      RD_DATA   <= '0;
      DATA_RDY  <= 1'b0;
      MDIO_DONE <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      state_q   <= StIdle;
      frame_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= 5'd31;
      armed_q   <= 1'b0;
    end else begin
      MDC       <= ~MDC;
      ERR       <= 1'b0;
      DATA_RDY  <= 1'b0;
      MDIO_DONE <= 1'b0;

      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= 5'd31;
          if (armed_q) begin
            // Accepted frame waits here until the next MDC falling edge presents bit 31.
            if (mdc_fall) begin
              state_q  <= StSendHdr;
              armed_q  <= 1'b0;
              MDIO_OE  <= 1'b1;
              MDIO_OUT <= frame_q[31];
            end
          end else if (MDIO_START) begin
            if (frame_ok) begin
              frame_q <= T_DATA;
              armed_q <= 1'b1;
              BUSY    <= 1'b1;
            end else begin
              ERR <= 1'b1;
            end
          end
        end

        StSendHdr: begin
          if (mdc_fall) begin
            bit_cnt_q <= next_bit;
            if (bit_cnt_q == LastHdr) begin
              if (is_read) begin
                state_q  <= StTurn;
                MDIO_OE  <= 1'b0;
                MDIO_OUT <= 1'b0;
              end else begin
                state_q  <= StSendData;
                MDIO_OUT <= frame_q[next_bit];
              end
            end else begin
              MDIO_OUT <= frame_q[next_bit];
            end
          end
        end

        StTurn: begin
          if (mdc_fall) begin
            bit_cnt_q <= next_bit;
            if (bit_cnt_q == LastTa) begin
              state_q <= StReadData;
            end
          end
        end

        StReadData: begin
          if (mdc_fall) begin
            rx_q <= {rx_q[DATA_W-3:0], MDIO_IN};
            if (bit_cnt_q == 5'd0) begin
              state_q  <= StFinish;
              RD_DATA  <= {rx_q, MDIO_IN};
              DATA_RDY <= 1'b1;
              BUSY     <= 1'b0;
            end else begin
              bit_cnt_q <= next_bit;
            end
          end
        end

        StSendData: begin
          if (mdc_fall) begin
            if (bit_cnt_q == 5'd0) begin
              state_q   <= StFinish;
              MDIO_OE   <= 1'b0;
              MDIO_OUT  <= 1'b0;
              MDIO_DONE <= 1'b1;
              BUSY      <= 1'b0;
            end else begin
              bit_cnt_q <= next_bit;
              MDIO_OUT  <= frame_q[next_bit];
            end
          end
        end

        StFinish: begin
          // MDIO_START during the completion pulse is dropped; requester retries.
          state_q   <= StIdle;
          bit_cnt_q <= 5'd31;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller: behavioural MDIO peripheral plus a
// scoreboard of expected frame results popped on DATA_RDY / MDIO_DONE.
module tb_mdio_controller;

  logic        CLK;
  logic        RESET;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN = 1'b0;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        MDIO_DONE;
  logic        BUSY;
  logic        ERR;

  mdio_controller dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MDIO_START(MDIO_START),
    .T_DATA    (T_DATA),
    .MDIO_IN   (MDIO_IN),
    .MDC       (MDC),
    .MDIO_OE   (MDIO_OE),
    .MDIO_OUT  (MDIO_OUT),
    .RD_DATA   (RD_DATA),
    .DATA_RDY  (DATA_RDY),
    .MDIO_DONE (MDIO_DONE),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_read;
    logic [31:0] frame;
    logic [15:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          start_cyc   = 0;
  int          frame_start = 0;
  int          oe_rises    = 0;
  bit          oe_prev     = 1'b0;
  bit          prev_pulse  = 1'b0;
  logic [15:0] model_rd    = 16'h0;

  // Peripheral model state
  int          per_idx     = -1;
  logic [31:0] per_frame   = 32'h0;
  logic [31:0] per_oe      = 32'h0;
  logic [15:0] per_rd_val  = 16'h0;
  logic [31:0] cap_frame   = 32'h0;
  logic [31:0] cap_oe      = 32'h0;
  logic [4:0]  wr_addr     = 5'h0;
  logic [15:0] wr_data     = 16'h0;
  int          wr_stb_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Peripheral samples on MDC rise and updates MDIO_IN on MDC rise.
  always @(posedge MDC or negedge RESET) begin
    if (!RESET) begin
      per_idx = -1;
      MDIO_IN = 1'b0;
    end else begin
      if (per_idx < 0 && MDIO_OE) per_idx = 31;
      if (per_idx >= 0) begin
        per_frame[per_idx] = MDIO_OUT;
        per_oe[per_idx]    = MDIO_OE;
        if (per_idx <= 15 && per_frame[29:28] == 2'b10) MDIO_IN = per_rd_val[per_idx];
        if (per_idx == 0) begin
          cap_frame = per_frame;
          cap_oe    = per_oe;
          if (per_frame[29:28] == 2'b01) begin
            wr_addr = per_frame[22:18];
            wr_data = per_frame[15:0];
            wr_stb_cnt++;
          end
        end
        per_idx--;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      if (prev_pulse) check_eq("pulse_width", {30'd0, DATA_RDY, MDIO_DONE}, 32'd0);
      if (MDIO_OE && !oe_prev) begin
        check_eq("start_align", ((cyc - start_cyc) == 1 || (cyc - start_cyc) == 2) ? 1 : 0, 1);
        frame_start = cyc;
        oe_rises++;
      end
      if (DATA_RDY || MDIO_DONE) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", {30'd0, DATA_RDY, MDIO_DONE}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("frame_len", cyc - frame_start, 64);
          check_eq("end_busy_oe", {29'd0, BUSY, MDIO_OE, MDIO_OUT}, 32'd0);
          if (e.is_read) begin
            check_eq("rd_pulse", {30'd0, DATA_RDY, MDIO_DONE}, 32'd2);
            check_eq("rd_data", RD_DATA, e.rd);
            check_eq("rd_hdr", cap_frame[31:18], e.frame[31:18]);
            check_eq("rd_oe", cap_oe, 32'hFFFC0000);
            model_rd = e.rd;
          end else begin
            check_eq("wr_pulse", {30'd0, DATA_RDY, MDIO_DONE}, 32'd1);
            check_eq("wr_frame", cap_frame, e.frame);
            check_eq("wr_oe", cap_oe, 32'hFFFFFFFF);
            check_eq("rd_hold", RD_DATA, model_rd);
          end
          cap_frame = 32'h0;
          cap_oe    = 32'h0;
        end
      end
      prev_pulse = DATA_RDY || MDIO_DONE;
    end else begin
      prev_pulse = 1'b0;
    end
    oe_prev = MDIO_OE;
  end

  task automatic issue_frame(input logic [31:0] frame, input logic [15:0] rd, input bit push);
    exp_t e;
    @(negedge CLK);
    if (push) begin
      e.is_read = (frame[29:28] == 2'b10);
      e.frame   = frame;
      e.rd      = rd;
      exp_q.push_back(e);
      per_rd_val = rd;
      start_cyc  = cyc + 1;
    end
    MDIO_START = 1'b1;
    T_DATA     = frame;
    @(negedge CLK);
    MDIO_START = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) begin
      check_eq("drain_timeout", 1, 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_rdy(input int limit);
    int n = 0;
    while (!DATA_RDY && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) check_eq("rdy_timeout", 1, 0);
  endtask

  task automatic wait_per_idx(input int idx, input int limit);
    int n = 0;
    while (!(per_idx >= 0 && per_idx <= idx) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) check_eq("bit_timeout", 1, 0);
  endtask

  logic [31:0] bad_frames[2];

  initial begin
    int stb;
    int rises;
    bad_frames[0] = 32'h708C0000;
    bad_frames[1] = 32'hC08C0000;
    RESET      = 1'b0;
    MDIO_START = 1'b0;
    T_DATA     = 32'h0;
    repeat (3) @(negedge CLK);
    check_eq("reset_ctl", {25'd0, MDC, MDIO_OE, MDIO_OUT, DATA_RDY, MDIO_DONE, BUSY, ERR}, 32'd0);
    check_eq("reset_rd", RD_DATA, 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Write
    issue_frame(32'h508EA5A5, 16'h0, 1'b1);
    check_eq("wr_busy", BUSY, 1);
    wait_drain(200);
    check_eq("wr_stb", wr_stb_cnt, 1);
    check_eq("wr_addr", wr_addr, 5'd3);
    check_eq("wr_data", wr_data, 16'hA5A5);

    // Read
    issue_frame(32'h608C0000, 16'h3C5A, 1'b1);
    wait_drain(200);
    check_eq("rd_result", RD_DATA, 16'h3C5A);

    // Malformed frames
    foreach (bad_frames[i]) begin
      rises = oe_rises;
      issue_frame(bad_frames[i], 16'h0, 1'b0);
      check_eq("err_pulse", ERR, 1);
      check_eq("err_idle", {30'd0, BUSY, MDIO_OE}, 32'd0);
      @(negedge CLK);
      check_eq("err_width", ERR, 0);
      repeat (8) @(negedge CLK);
      check_eq("err_no_frame", oe_rises - rises, 0);
      check_eq("err_bus", {30'd0, BUSY, MDIO_OUT}, 32'd0);
    end

    // START while busy is ignored
    issue_frame(32'h608C0000, 16'hA55A, 1'b1);
    wait_per_idx(20, 200);
    stb = wr_stb_cnt;
    issue_frame(32'h508E0001, 16'h0, 1'b0);
    check_eq("busy_no_err", ERR, 0);
    check_eq("busy_held", BUSY, 1);
    wait_drain(200);
    check_eq("busy_rd", RD_DATA, 16'hA55A);
    repeat (80) @(negedge CLK);
    check_eq("busy_no_2nd", wr_stb_cnt - stb, 0);
    check_eq("busy_idle", BUSY, 0);

    // Reset mid-read
    issue_frame(32'h608C0000, 16'h0F0F, 1'b1);
    wait_per_idx(10, 200);
    #2;
    RESET = 1'b0;
    #1;
    check_eq("rst_mid_ctl", {27'd0, MDC, MDIO_OE, BUSY, DATA_RDY, MDIO_DONE}, 32'd0);
    check_eq("rst_mid_rd", RD_DATA, 32'd0);
    exp_q.delete();
    model_rd = 16'h0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    issue_frame(32'h508E1234, 16'h0, 1'b1);
    wait_drain(200);
    check_eq("rst_wr_data", wr_data, 16'h1234);
    check_eq("rst_wr_addr", wr_addr, 5'd3);

    // Back-to-back read then write
    issue_frame(32'h608C0000, 16'hC3A5, 1'b1);
    wait_rdy(200);
    issue_frame(32'h508E5A5A, 16'h0, 1'b1);
    wait_drain(200);
    check_eq("b2b_rd", RD_DATA, 16'hC3A5);
    check_eq("b2b_wr", wr_data, 16'h5A5A);

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
